cpu16_alu_fa: RTL and testbench
===============================

# cpu16_alu_fa

One-bit full-adder slice for the cpu16 ALU datapath. Produces the sum and carry of A, B and a carry-in combinationally with zero latency, and registers both results for pipelined use. It also provides a bit-serial mode: a 16-bit word is added LSB first over 16 cycles, with the carry held in an internal register.

## Interface
Parameters: none.

Ports (clk, rst_n listed first; the first five positional ports in RTL are A, B, Cin, R, Cout, in that order, with the remainder following):
- clk  input  1  single system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- A  input  1  addend bit
- B  input  1  addend bit
- Cin  input  1  external carry-in
- R  output  1  combinational sum
- Cout  output  1  combinational carry-out
- serial_en  input  1  bit-serial mode: carry source is carry_q, not Cin
- serial_clr  input  1  start of serial word: load carry_q from Cin, clear bit_cnt
- R_q  output  1  registered R
- Cout_q  output  1  registered Cout
- carry_q  output  1  serial carry register
- bit_cnt  output  4  serial bit index, 0..15
- word_done  output  1  registered pulse after the 16th serial bit

## Operation
- Effective carry: c = (serial_en && !serial_clr) ? carry_q : Cin.
- Sum and carry:
  - R = A ^ B ^ c.
  - Cout = (A & B) | (A & c) | (B & c).
  - Pure combinational logic, independent of clk.
- Every clock edge: R_q <= R, Cout_q <= Cout.
- serial_clr = 1 (priority over serial_en): carry_q <= Cin, bit_cnt <= 0, word_done <= 0.
- serial_en = 1 and serial_clr = 0:
  - carry_q <= Cout.
  - bit_cnt <= bit_cnt + 1, wrapping 15 -> 0.
  - word_done <= (bit_cnt == 15), else 0.
- Both serial_en and serial_clr = 0: carry_q and bit_cnt hold, word_done <= 0.
- The next word's serial_clr may coincide with the word_done cycle.

## Timing
- R, Cout: zero-cycle latency; valid one propagation delay after any input change.
- R_q, Cout_q, carry_q, bit_cnt, word_done: one-cycle latency.
- Reset values: R_q = 0, Cout_q = 0, carry_q = 0, bit_cnt = 0, word_done = 0.
- Reset asserted mid-word aborts the word immediately, without waiting for a clock edge. After release, a new serial_clr is needed before serial operation.
- word_done is high for exactly one cycle per 16 consecutive serial_en cycles.

## Configuration
- CPU16_ALU_FA_SERIAL_EN defined:
  - Serial logic is present, as described above.
- CPU16_ALU_FA_SERIAL_EN undefined:
  - serial_en and serial_clr are ignored; c = Cin always.
  - carry_q, bit_cnt and word_done are tied to 0.
  - R, Cout, R_q and Cout_q are unchanged.

## Test plan
- Exhaustive truth table, serial_en = 0, 10-unit steps:
  - (A,B,Cin) 000 -> R=0, Cout=0; 001 -> 1,0; 010 -> 1,0; 011 -> 0,1.
  - 100 -> 1,0; 101 -> 0,1; 110 -> 0,1; 111 -> 1,1.
  - R and Cout settle within the same step.
- Registered path: apply A=1, B=1, Cin=1 before an edge -> after that edge R_q=1, Cout_q=1, matching R/Cout from the previous cycle.
- Serial add, 16 bits:
  - serial_clr with Cin=0, then stream 0x7FFF + 0x0001 LSB first.
  - R bits form 0x8000.
  - carry_q = 0 after the last bit; word_done pulses once, with bit_cnt wrapped to 0.
- Serial carry-out and carry-in:
  - 0xFFFF + 0x0001 -> sum 0x0000, carry_q = 1 at word end.
  - serial_clr with Cin=1 and 0x0000 + 0x0000 -> sum 0x0001.
- Async reset mid-word: assert rst_n=0 at bit 7 -> carry_q, bit_cnt, R_q, Cout_q and word_done go to 0 without a clock edge; no word_done follows.
- Macro undefined: serial_en=1, Cin=1, A=B=0 -> R=1; carry_q and bit_cnt stay 0.

Source files
------------

// File: rtl/cpu16_alu_fa.sv
// cpu16_alu_fa: one-bit full-adder slice for the cpu16 ALU datapath.
//
// R/Cout are purely combinational. R_q/Cout_q are their values registered on
// every rising edge of clk. An optional bit-serial mode adds a 16-bit word
// LSB first over 16 cycles, keeping the running carry in carry_q.
//
// Build option: define CPU16_ALU_FA_SERIAL_EN to include the serial logic.
// Without it, serial_en/serial_clr are ignored, the carry source is always
// Cin, and carry_q, bit_cnt and word_done are tied to 0.
//
// Ports:
//   A, B       addend bits
//   Cin        external carry-in
//   R, Cout    combinational sum / carry-out
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   serial_en  bit-serial mode, carry taken from carry_q
//   serial_clr start of serial word: carry_q <= Cin, bit_cnt <= 0
//   R_q        registered R
//   Cout_q     registered Cout
//   carry_q    serial carry register
//   bit_cnt    serial bit index 0..15
//   word_done  one-cycle pulse after the 16th serial bit

module cpu16_alu_fa (
   input  logic       A,
   input  logic       B,
   input  logic       Cin,
   output logic       R,
   output logic       Cout,
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_en,
   input  logic       serial_clr,
   output logic       R_q,
   output logic       Cout_q,
   output logic       carry_q,
   output logic [3:0] bit_cnt,
   output logic       word_done
);

   logic c;

`ifdef CPU16_ALU_FA_SERIAL_EN
   // serial_clr wins: the clearing cycle still adds with the external Cin.
   assign c = (serial_en && !serial_clr) ? carry_q : Cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q   <= 1'b0;
         bit_cnt   <= 4'd0;
         word_done <= 1'b0;
      end else if (serial_clr) begin
         carry_q   <= Cin;
         bit_cnt   <= 4'd0;
         word_done <= 1'b0;
      end else if (serial_en) begin
         carry_q   <= Cout;
         bit_cnt   <= bit_cnt + 4'd1;
         word_done <= (bit_cnt == 4'd15);
      end else begin
         word_done <= 1'b0;
      end
   end
`else
   assign c         = Cin;
   assign carry_q   = 1'b0;
   assign bit_cnt   = 4'd0;
   assign word_done = 1'b0;

   logic unused_serial;
   assign unused_serial = &{1'b0, serial_en, serial_clr};
`endif

   assign R    = A ^ B ^ c;
   assign Cout = (A & B) | (A & c) | (B & c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         R_q    <= 1'b0;
         Cout_q <= 1'b0;
      end else begin
         R_q    <= R;
         Cout_q <= Cout;
      end
   end

endmodule

// File: tb/tb_cpu16_alu_fa.sv
// Directed testbench for cpu16_alu_fa: truth table, registered path, async
// reset, and either the serial word tests (serial build) or the tie-off
// behaviour (default build).

module tb_cpu16_alu_fa;

   logic       clk;
   logic       rst_n;
   logic       A, B, Cin;
   logic       serial_en, serial_clr;
   logic       R, Cout, R_q, Cout_q, carry_q, word_done;
   logic [3:0] bit_cnt;

   int n_checks = 0;
   int n_errors = 0;

   cpu16_alu_fa dut (
      .A          (A),
      .B          (B),
      .Cin        (Cin),
      .R          (R),
      .Cout       (Cout),
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_en  (serial_en),
      .serial_clr (serial_clr),
      .R_q        (R_q),
      .Cout_q     (Cout_q),
      .carry_q    (carry_q),
      .bit_cnt    (bit_cnt),
      .word_done  (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

`ifdef CPU16_ALU_FA_SERIAL_EN
   // Clear with cin, then stream a + b LSB first; sum bits captured from R.
   task automatic serial_word(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              output logic [15:0] sum, output int done_cnt);
      done_cnt = 0;
      @(negedge clk);
      serial_clr = 1'b1;
      serial_en  = 1'b0;
      Cin        = cin;
      A          = 1'b0;
      B          = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         serial_clr = 1'b0;
         serial_en  = 1'b1;
         Cin        = 1'b0;
         A          = a[i];
         B          = b[i];
         #1 sum[i] = R;
         @(posedge clk);
         #1 if (word_done) done_cnt++;
      end
   endtask
`endif

   logic [7:0] exp_r;
   logic [7:0] exp_c;
   logic [2:0] v;
   logic [15:0] sum;
   int          done_cnt;

   initial begin
      rst_n = 1'b0;
      A = 0; B = 0; Cin = 0;
      serial_en = 0; serial_clr = 0;
      #12;
      chk("rst_R_q", R_q, 0);
      chk("rst_Cout_q", Cout_q, 0);
      chk("rst_carry_q", carry_q, 0);
      chk("rst_bit_cnt", bit_cnt, 0);
      chk("rst_word_done", word_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Truth table, index = {A,B,Cin}
      exp_r = 8'h96;
      exp_c = 8'hE8;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         A = v[2]; B = v[1]; Cin = v[0];
         #10;
         chk($sformatf("tt_R_%0d", i), R, exp_r[i]);
         chk($sformatf("tt_Cout_%0d", i), Cout, exp_c[i]);
      end

      // Registered path
      @(negedge clk);
      A = 1; B = 1; Cin = 1;
      @(posedge clk);
      #1;
      chk("reg_R_q", R_q, 1);
      chk("reg_Cout_q", Cout_q, 1);
      @(negedge clk);
      A = 0; B = 0; Cin = 0;
      #1;
      chk("reg_hold_R_q", R_q, 1);
      chk("reg_hold_Cout_q", Cout_q, 1);
      chk("comb_R_now", R, 0);

      // Async reset clears registers without a clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("arst_R_q", R_q, 0);
      chk("arst_Cout_q", Cout_q, 0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef CPU16_ALU_FA_SERIAL_EN
      serial_word(16'h7FFF, 16'h0001, 1'b0, sum, done_cnt);
      chk("s1_sum", sum, 16'h8000);
      chk("s1_carry_q", carry_q, 0);
      chk("s1_done_cnt", done_cnt, 1);
      chk("s1_bit_cnt", bit_cnt, 0);
      chk("s1_word_done", word_done, 1);
      @(negedge clk);
      serial_en = 0;
      @(posedge clk);
      #1;
      chk("s1_done_drop", word_done, 0);
      chk("s1_bit_cnt_hold", bit_cnt, 0);

      serial_word(16'hFFFF, 16'h0001, 1'b0, sum, done_cnt);
      chk("s2_sum", sum, 16'h0000);
      chk("s2_carry_q", carry_q, 1);
      chk("s2_done_cnt", done_cnt, 1);

      // Next word's clear coincides with word_done
      serial_word(16'h0000, 16'h0000, 1'b1, sum, done_cnt);
      chk("s3_sum", sum, 16'h0001);
      chk("s3_carry_q", carry_q, 0);
      chk("s3_done_cnt", done_cnt, 1);
      @(negedge clk);
      serial_en = 0;

      // Reset mid-word at bit 7
      @(negedge clk);
      serial_clr = 1; Cin = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         serial_clr = 0; serial_en = 1;
         A = 1; B = 1;
      end
      @(posedge clk);
      #1;
      chk("mid_bit_cnt", bit_cnt, 7);
      chk("mid_carry_q", carry_q, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_carry_q", carry_q, 0);
      chk("mid_rst_bit_cnt", bit_cnt, 0);
      chk("mid_rst_R_q", R_q, 0);
      chk("mid_rst_Cout_q", Cout_q, 0);
      chk("mid_rst_word_done", word_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      A = 0; B = 0;
      done_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1 if (word_done) done_cnt++;
      end
      chk("mid_no_done", done_cnt, 0);
      @(negedge clk);
      serial_en = 0;
`else
      // Serial controls ignored in the default build
      @(negedge clk);
      serial_en = 1; serial_clr = 0; Cin = 1; A = 0; B = 0;
      #1;
      chk("nos_R", R, 1);
      chk("nos_Cout", Cout, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("nos_carry_q", carry_q, 0);
      chk("nos_bit_cnt", bit_cnt, 0);
      chk("nos_word_done", word_done, 0);
      chk("nos_R_q", R_q, 1);
      @(negedge clk);
      serial_clr = 1; A = 1; B = 0; Cin = 1;
      #1;
      chk("nos_clr_Cout", Cout, 1);
      @(posedge clk);
      #1;
      chk("nos_clr_carry_q", carry_q, 0);
      chk("nos_clr_Cout_q", Cout_q, 1);
      @(negedge clk);
      serial_en = 0; serial_clr = 0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
